// File: rtl/ball_controller.sv
// Pong game sequencer: ball position/direction, serve hold, paddle/wall collisions and scoring.
// Advances once per frame_tick; every output is a flop updated on the pixel_clk edge.
`timescale 1ns/1ps
module ball_controller #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SPEED          = 2,
  parameter int SERVE_FRAMES   = 60,
  parameter int WIN_SCORE      = 7
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] left_paddle_y,
  input  logic [9:0] right_paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_visible,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       game_over,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [9:0]  CX       = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  CY       = 10'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [10:0] SPD      = 11'(SPEED);
  localparam logic [10:0] BS       = 11'(BALL_SIZE);
  localparam logic [10:0] PH       = 11'(PADDLE_H);
  localparam logic [10:0] SW       = 11'(SCREEN_W);
  localparam logic [10:0] SH       = 11'(SCREEN_H);
  localparam logic [10:0] L_FACE   = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] R_FACE   = 11'(RIGHT_PADDLE_X);
  localparam logic [15:0] CNT_LOAD = 16'((SERVE_FRAMES == 0) ? 1 : SERVE_FRAMES);
  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

  state_t      state_q, state_d;
  logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic        dx_q, dx_d;   // 1 = moving right
  logic        dy_q, dy_d;   // 1 = moving down
  logic [3:0]  left_score_q, left_score_d, right_score_q, right_score_d;
  logic [15:0] cnt_q, cnt_d;
  logic        left_scored_q, left_scored_d;
  logic        visible_q, visible_d, game_over_q, game_over_d;

  logic [10:0] x11, y11, lp11, rp11, px, py;
  logic        pdx, pdy, ovl_l, ovl_r, miss, miss_left_scores;
  logic [3:0]  new_score;

  // Candidate PLAY update; both axes use the pre-tick position.
  always_comb begin
    x11   = {1'b0, ball_x_q};
    y11   = {1'b0, ball_y_q};
    lp11  = {1'b0, left_paddle_y};
    rp11  = {1'b0, right_paddle_y};
    ovl_l = (y11 + BS > lp11) && (y11 < lp11 + PH);
    ovl_r = (y11 + BS > rp11) && (y11 < rp11 + PH);
    px    = x11;
    py    = y11;
    pdx   = dx_q;
    pdy   = dy_q;
    miss  = 1'b0;
    miss_left_scores = 1'b0;

    if (!dy_q) begin
      if (y11 <= SPD) begin
        py  = 11'd0;
        pdy = 1'b1;
      end else begin
        py  = y11 - SPD;
      end
    end else begin
      if (y11 + BS + SPD >= SH) begin
        py  = SH - BS;
        pdy = 1'b0;
      end else begin
        py  = y11 + SPD;
      end
    end

    // Hit needs the ball at or in front of the face; behind it only the miss boundary applies.
    if (!dx_q) begin
      if ((x11 >= L_FACE) && (x11 - SPD <= L_FACE) && ovl_l) begin
        px  = L_FACE;
        pdx = 1'b1;
      end else if (x11 <= SPD) begin
        px   = 11'd0;
        miss = 1'b1;
        miss_left_scores = 1'b0;
      end else begin
        px  = x11 - SPD;
      end
    end else begin
      if ((x11 + BS <= R_FACE) && (x11 + BS + SPD >= R_FACE) && ovl_r) begin
        px  = R_FACE - BS;
        pdx = 1'b0;
      end else if (x11 + BS + SPD >= SW) begin
        px   = SW - BS;
        miss = 1'b1;
        miss_left_scores = 1'b1;
      end else begin
        px  = x11 + SPD;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    cnt_d         = cnt_q;
    left_scored_d = left_scored_q;
    new_score     = (left_scored_q ? left_score_q : right_score_q) + 4'd1;

    case (state_q)
      S_IDLE: begin
        ball_x_d = CX;
        ball_y_d = CY;
        if (start) begin
          state_d = S_SERVE;
          cnt_d   = CNT_LOAD;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q <= 16'd1) begin
            cnt_d   = 16'd0;
            state_d = S_PLAY;
          end else begin
            cnt_d   = cnt_q - 16'd1;
          end
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          ball_x_d = px[9:0];
          ball_y_d = py[9:0];
          dx_d     = pdx;
          dy_d     = pdy;
          if (miss) begin
            state_d       = S_POINT;
            left_scored_d = miss_left_scores;
          end
        end
      end
      S_POINT: begin
        if (left_scored_q) left_score_d = new_score;
        else               right_score_d = new_score;
        if (new_score == WIN) begin
          state_d = S_GAME_OVER;
        end else begin
          ball_x_d = CX;
          ball_y_d = CY;
          dx_d     = left_scored_q;  // serve toward the player who conceded
          cnt_d    = CNT_LOAD;
          state_d  = S_SERVE;
        end
      end
      S_GAME_OVER: begin
        if (start) begin
          left_score_d  = 4'd0;
          right_score_d = 4'd0;
          ball_x_d      = CX;
          ball_y_d      = CY;
          dx_d          = 1'b1;
          dy_d          = 1'b1;
          cnt_d         = CNT_LOAD;
          state_d       = S_SERVE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    visible_d   = (state_d != S_GAME_OVER);
    game_over_d = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ball_x_q      <= CX;
      ball_y_q      <= CY;
      dx_q          <= 1'b1;
      dy_q          <= 1'b1;
      left_score_q  <= 4'd0;
      right_score_q <= 4'd0;
      cnt_q         <= 16'd0;
      left_scored_q <= 1'b0;
      visible_q     <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      cnt_q         <= cnt_d;
      left_scored_q <= left_scored_d;
      visible_q     <= visible_d;
      game_over_q   <= game_over_d;
    end
  end

  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign ball_visible = visible_q;
  assign left_score   = left_score_q;
  assign right_score  = right_score_q;
  assign game_over    = game_over_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ball_controller.sv
// Directed bench for ball_controller: serve timing, wall bounces, paddle hits/misses,
// scoring through to game over and restart, with hand-computed trajectory points.
`timescale 1ns/1ps
module tb_ball_controller;

  localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_GAME_OVER = 4;

  logic       pixel_clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic       start;
  logic [9:0] left_paddle_y;
  logic [9:0] right_paddle_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       ball_visible;
  logic [3:0] left_score;
  logic [3:0] right_score;
  logic       game_over;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  ball_controller dut (
    .pixel_clk      (pixel_clk),
    .reset_n        (reset_n),
    .frame_tick     (frame_tick),
    .start          (start),
    .left_paddle_y  (left_paddle_y),
    .right_paddle_y (right_paddle_y),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .ball_visible   (ball_visible),
    .left_score     (left_score),
    .right_score    (right_score),
    .game_over      (game_over),
    .dbg_state      (dbg_state)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame pulse, then two idle cycles so a POINT cycle has resolved before sampling.
  task automatic tick();
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    @(negedge pixel_clk);
    @(negedge pixel_clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    @(negedge pixel_clk) start = 1'b1;
    @(negedge pixel_clk) start = 1'b0;
    @(negedge pixel_clk);
  endtask

  task automatic check_pos(input string tag, input int x, input int y);
    check_val({tag, "_x"}, int'(ball_x), x);
    check_val({tag, "_y"}, int'(ball_y), y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    frame_tick     = 1'b0;
    start          = 1'b0;
    left_paddle_y  = 10'd1000;
    right_paddle_y = 10'd1000;
    repeat (3) @(negedge pixel_clk);
    check_pos("rst", 316, 236);
    check_val("rst_state", int'(dbg_state), ST_IDLE);
    check_val("rst_vis", int'(ball_visible), 1);
    check_val("rst_go", int'(game_over), 0);
    check_val("rst_ls", int'(left_score), 0);
    check_val("rst_rs", int'(right_score), 0);
    @(negedge pixel_clk) reset_n = 1'b1;

    // Reset in the middle of play.
    pulse_start();
    check_val("a_serve", int'(dbg_state), ST_SERVE);
    ticks(60);
    check_val("a_play", int'(dbg_state), ST_PLAY);
    ticks(42);
    check_pos("a_mid", 400, 320);
    @(negedge pixel_clk);
    #2 reset_n = 1'b0;
    #1 check_pos("a_async_rst", 316, 236);
    @(negedge pixel_clk) reset_n = 1'b1;
    ticks(3);
    check_val("a_idle", int'(dbg_state), ST_IDLE);
    check_pos("a_idle", 316, 236);
    check_val("a_ls", int'(left_score), 0);
    check_val("a_rs", int'(right_score), 0);

    // Serve: a tick coincident with start is ignored, start during serve is ignored.
    right_paddle_y = 10'd412;
    left_paddle_y  = 10'd0;
    @(negedge pixel_clk) begin start = 1'b1; frame_tick = 1'b1; end
    @(negedge pixel_clk) begin start = 1'b0; frame_tick = 1'b0; end
    @(negedge pixel_clk);
    check_val("b_serve", int'(dbg_state), ST_SERVE);
    ticks(30);
    pulse_start();
    ticks(29);
    check_val("b_serve59", int'(dbg_state), ST_SERVE);
    check_pos("b_hold59", 316, 236);
    tick();
    check_val("b_play", int'(dbg_state), ST_PLAY);
    check_pos("b_hold60", 316, 236);
    tick();
    check_pos("b_first", 318, 238);
    ticks(116);
    check_pos("b_pre_bottom", 550, 470);
    tick();
    check_pos("b_bottom", 552, 472);
    tick();
    check_pos("b_after_bottom", 554, 470);
    ticks(26);
    check_pos("b_pre_rhit", 606, 418);
    tick();
    check_pos("b_rhit", 608, 416);
    tick();
    check_pos("b_after_rhit", 606, 414);
    ticks(206);
    check_pos("b_pre_top", 194, 2);
    tick();
    check_pos("b_top", 192, 0);
    tick();
    check_pos("b_after_top", 190, 2);
    ticks(83);
    check_val("b_lpass_x", int'(ball_x), 24);
    tick();
    check_val("b_behind_x", int'(ball_x), 22);
    ticks(10);
    check_val("b_pre_miss_x", int'(ball_x), 2);
    tick();
    check_val("b_rs", int'(right_score), 1);
    check_val("b_ls", int'(left_score), 0);
    check_val("b_reserve", int'(dbg_state), ST_SERVE);
    check_pos("b_reserve", 316, 236);

    // Re-serve heads left; left paddle deflects at its face.
    left_paddle_y = 10'd414;
    ticks(60);
    check_val("c_play", int'(dbg_state), ST_PLAY);
    ticks(117);
    check_pos("c_pre_bottom", 82, 470);
    tick();
    check_pos("c_bottom", 80, 472);
    ticks(27);
    check_pos("c_pre_lhit", 26, 418);
    tick();
    check_pos("c_lhit", 24, 416);
    tick();
    check_pos("c_after_lhit", 26, 414);

    // Left player scores every rally until the game ends.
    left_paddle_y  = 10'd1000;
    right_paddle_y = 10'd1000;
    for (int i = 1; i <= 7; i++) begin
      int guard;
      guard = 0;
      while (left_score == 4'(i - 1) && guard < 600) begin
        tick();
        guard++;
      end
      check_val($sformatf("d_ls%0d", i), int'(left_score), i);
      check_val($sformatf("d_rs%0d", i), int'(right_score), 1);
      if (i < 7) check_val($sformatf("d_state%0d", i), int'(dbg_state), ST_SERVE);
    end
    check_val("d_go", int'(game_over), 1);
    check_val("d_vis", int'(ball_visible), 0);
    check_val("d_state", int'(dbg_state), ST_GAME_OVER);
    ticks(3);
    check_val("d_hold_ls", int'(left_score), 7);
    check_val("d_hold_rs", int'(right_score), 1);
    check_val("d_hold_go", int'(game_over), 1);
    check_val("d_hold_state", int'(dbg_state), ST_GAME_OVER);

    // Restart from game over.
    pulse_start();
    check_val("e_state", int'(dbg_state), ST_SERVE);
    check_val("e_ls", int'(left_score), 0);
    check_val("e_rs", int'(right_score), 0);
    check_val("e_go", int'(game_over), 0);
    check_val("e_vis", int'(ball_visible), 1);
    check_pos("e_centre", 316, 236);
    ticks(60);
    tick();
    check_pos("e_first", 318, 238);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
